// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
// The master drives the request side; the slave returns the busy/done handshake and result.
interface riscv_muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output start, funct3, a, b, rd_in, flush,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, funct3, a, b, rd_in, flush,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/riscv_muldiv.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider on operand magnitudes,
// with a final sign-fix cycle and a one-cycle fast path for divide-by-zero and signed overflow.
module riscv_muldiv #(
   parameter int XLEN = 32
) (
   input logic           clk,
   input logic           rst,
   riscv_muldiv_if.slave bus
);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [2:0]        op_r;
   logic              sign_a_r, sign_b_r;
   logic [XLEN-1:0]   opnd_r;
   logic [2*XLEN-1:0] acc_r;
   logic [XLEN:0]     rem_r;
   logic [CW-1:0]     cnt_r;
   logic              busy_r, done_r;
   logic [XLEN-1:0]   result_r;
   logic [4:0]        rd_r;

   logic              start_s, flush_s, accept_s, fast_s, is_div_s;
   logic              a_signed_s, b_signed_s, div0_s, ovf_s;
   logic [2:0]        funct3_s;
   logic [XLEN-1:0]   a_s, b_s, mag_a_s, mag_b_s, fast_res_s;
   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_next_s, prod_s;
   logic [XLEN+1:0]   div_shift_s, div_trial_s;
   logic [XLEN-1:0]   quo_s, rem_fix_s, fix_res_s;

   // Request decode: operand signedness, magnitudes and the fast-path result
   always_comb begin
      start_s    = bus.start;
      flush_s    = bus.flush;
      funct3_s   = bus.funct3;
      a_s        = bus.a;
      b_s        = bus.b;
      is_div_s   = funct3_s[2];
      a_signed_s = (funct3_s != 3'b011) && (funct3_s != 3'b101) && (funct3_s != 3'b111);
      b_signed_s = (funct3_s == 3'b000) || (funct3_s == 3'b001) ||
                   (funct3_s == 3'b100) || (funct3_s == 3'b110);
      mag_a_s    = (a_signed_s && a_s[XLEN-1]) ? -a_s : a_s;
      mag_b_s    = (b_signed_s && b_s[XLEN-1]) ? -b_s : b_s;
      div0_s     = is_div_s && (b_s == {XLEN{1'b0}});
      ovf_s      = is_div_s && !funct3_s[0] && (b_s == {XLEN{1'b1}}) &&
                   (a_s == {1'b1, {(XLEN-1){1'b0}}});
      fast_s     = div0_s || ovf_s;
      if (div0_s) begin
         fast_res_s = funct3_s[1] ? a_s : {XLEN{1'b1}};
      end else begin
         fast_res_s = funct3_s[1] ? {XLEN{1'b0}} : a_s;
      end
      accept_s   = (state_r == IDLE) && start_s && !flush_s;
   end

   // One iteration step of each algorithm plus the sign-corrected final result
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                    (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
      mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
      // Partial remainder stays below the divisor, so the top bit of the trial is its sign
      div_shift_s = {rem_r, acc_r[XLEN-1]};
      div_trial_s = div_shift_s - {2'b00, opnd_r};
      prod_s      = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
      quo_s       = (sign_a_r ^ sign_b_r) ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      rem_fix_s   = sign_a_r ? -rem_r[XLEN-1:0] : rem_r[XLEN-1:0];
      case (op_r)
         3'b000:                 fix_res_s = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res_s = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res_s = quo_s;
         3'b110, 3'b111:         fix_res_s = rem_fix_s;
         default:                fix_res_s = {XLEN{1'b0}};
      endcase
   end

   // Next-state logic; flush wins over everything including a new start
   always_comb begin
      state_s = state_r;
      if (flush_s) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) state_s = fast_s ? DONE : CALC;
               else         state_s = IDLE;
            end
            CALC: begin
               if (cnt_r == CW'(XLEN - 1)) state_s = FIX;
               else                        state_s = CALC;
            end
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
         endcase
      end
   end

   // State register with registered busy/done derived from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
      end
   end

   // Datapath: capture at accept, iterate in CALC, publish the result at FIX or fast path
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r     <= 3'b000;
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         opnd_r   <= {XLEN{1'b0}};
         acc_r    <= {(2*XLEN){1'b0}};
         rem_r    <= {(XLEN+1){1'b0}};
         cnt_r    <= {CW{1'b0}};
         result_r <= {XLEN{1'b0}};
         rd_r     <= 5'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  op_r     <= funct3_s;
                  rd_r     <= bus.rd_in;
                  sign_a_r <= a_signed_s && a_s[XLEN-1];
                  sign_b_r <= b_signed_s && b_s[XLEN-1];
                  opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
                  acc_r    <= {{XLEN{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                  rem_r    <= {(XLEN+1){1'b0}};
                  cnt_r    <= {CW{1'b0}};
                  if (fast_s) result_r <= fast_res_s;
               end
            end
            CALC: begin
               cnt_r <= cnt_r + CW'(1);
               if (op_r[2]) begin
                  rem_r <= div_trial_s[XLEN+1] ? div_shift_s[XLEN:0] : div_trial_s[XLEN:0];
                  acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], ~div_trial_s[XLEN+1]};
               end else begin
                  acc_r <= mul_next_s;
               end
            end
            FIX: begin
               if (!flush_s) result_r <= fix_res_s;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.rd_out = rd_r;
endmodule

// File: doc/riscv_muldiv.md
# riscv_muldiv

Iterative multiply/divide unit adding the RV32M operations to the pipelined RISC-V core. It sits beside the execute-stage ALU. It accepts one operation at a time, computes it over multiple cycles with a shift-add multiplier or a restoring divider, and drives `busy` so the hazard unit can stall fetch and decode. Operand width is parametrised, and a flush input lets a taken branch kill an in-flight operation.

## Interface
- `XLEN`, default 32: operand and result width; must be at least 4.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand.
- `b`  in  XLEN  rs2 operand.
- `rd_in`  in  5  destination register tag.
- `flush`  in  1  abort the current operation; driven from PCSrcE/FlushE.
- `busy`  out  1  high from the accept edge until `done`; stall request to the hazard unit.
- `done`  out  1  one-cycle pulse; `result` and `rd_out` are valid during it.
- `result`  out  XLEN  final result, held until the next accept.
- `rd_out`  out  5  tag captured at accept.

## Operation
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - On `start` && !`flush`, capture `funct3`, `rd_in`, the operand signs and the operand magnitudes.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Go to CALC.
- **Fast path, from IDLE straight to DONE:**
  - Divide by zero (`b`==0): DIV/DIVU result = all ones; REM/REMU result = `a`.
  - Signed overflow (DIV/REM with `a`=100…0 and `b`=all ones): DIV result = `a`; REM result = 0.
- **CALC** runs exactly XLEN iterations, tracked by a counter of clog2(XLEN)+1 bits.
  - Multiply: shift-add over a 2·XLEN-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
  - Go to FIX after iteration XLEN-1.
- **FIX** applies the sign correction.
  - Product is negated (2·XLEN bits) if the operand signs differ.
  - Quotient is negated if sign(a)≠sign(b), signed ops only.
  - Remainder takes the sign of `a`.
  - Result select: MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - Register `result` and go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- **flush**: in any state, the next edge forces IDLE with `done`=0 and `busy`=0. `result` keeps its previous value. Flush beats a simultaneous `start`.
- `start` outside IDLE is ignored; no queueing.
- `start` in the DONE cycle is ignored. The earliest new accept is the cycle after `done`.
- Reset asserted mid-operation returns every register to its reset value immediately.

## Timing
- Accept at edge T. Normal path: `done` high in cycle T+XLEN+2, i.e. 34 cycles for XLEN=32.
- Fast path: `done` high in cycle T+1.
- `busy` rises at edge T and falls at the edge ending the `done` cycle.
- `busy` is a registered output with no combinational path from inputs. The hazard unit may use it directly.
- `result` changes only at the FIX→DONE edge or the fast-path IDLE→DONE edge.
- Throughput: one op per XLEN+3 cycles (normal path) or 2 cycles (fast path).

## Test plan
- **MUL/MULH (XLEN=32):** `a`=0xFFFFFFFF (−1), `b`=0x00000002. MUL → 0xFFFFFFFE, MULH → 0xFFFFFFFF, MULHU → 0x00000001, MULHSU → 0xFFFFFFFF. `done` exactly 34 cycles after accept; `rd_out` equals the captured tag.
- **Signed divide:** `a`=−7 (0xFFFFFFF9), `b`=2. DIV → 0xFFFFFFFD (−3), REM → 0xFFFFFFFF (−1), DIVU → 0x7FFFFFFC, REMU → 1.
- **Corner cases:**
  - `b`=0, `a`=0x1234: DIV → 0xFFFFFFFF, REM → 0x1234, `done` one cycle after accept.
  - `a`=0x80000000, `b`=0xFFFFFFFF: DIV → 0x80000000, REM → 0, one-cycle latency.
- **Flush:** accept DIV, assert `flush` in CALC iteration 10. Next cycle state is IDLE, `busy`=0, no `done` pulse, `result` unchanged. A `start` the following cycle is accepted and completes correctly.
- **Handshake:**
  - Pulse `start` with new operands while `busy`; the request is ignored and the original result is returned.
  - `start` with `flush` in IDLE is not accepted.
  - Back-to-back ops: the second accept occurs the cycle after `done`.
- **Reset:** drop `rst` asynchronously mid-CALC. All outputs read zero before the next clock edge. After release, a MULHU of 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
